tone_pwm_synth: RTL



---
 rtl/tone_pwm_synth.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/tone_pwm_synth.sv
// Keypad note decoder driving a glitch-free PWM tone with user duty in percent.
// Define TONE_ENVELOPE_EN to build the decaying release envelope.
module tone_pwm_synth #(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned DUTY_MAX    = 100,
  parameter int unsigned DUTY_STEP   = 5,
  parameter int unsigned DUTY_RESET  = 50,
  parameter int unsigned DECAY_TICKS = 1_000_000,
  localparam int unsigned DW = $clog2(DUTY_MAX + 1)
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          key_valid,
  input  logic [3:0]    key_code,
  input  logic          duty_up,
  input  logic          duty_down,
  output logic          tone_out,
  output logic [DW-1:0] duty,
  output logic [3:0]    note_idx,
  output logic          active
);

  localparam int unsigned P_MAX = CLK_HZ / 262;
  localparam int unsigned CW    = $clog2(P_MAX + 1);
  localparam int unsigned NW    = CW + DW;
  localparam int unsigned IW    = $clog2(NW + 1);

  typedef enum logic [1:0] {IDLE, PLAY, RELEASE} state_t;

  function automatic logic [CW-1:0] note_period(input logic [3:0] k);
    case (k)
      4'd0:    return CW'(CLK_HZ / 262);
      4'd1:    return CW'(CLK_HZ / 277);
      4'd2:    return CW'(CLK_HZ / 294);
      4'd3:    return CW'(CLK_HZ / 311);
      4'd4:    return CW'(CLK_HZ / 330);
      4'd5:    return CW'(CLK_HZ / 349);
      4'd6:    return CW'(CLK_HZ / 370);
      4'd7:    return CW'(CLK_HZ / 392);
      4'd8:    return CW'(CLK_HZ / 415);
      4'd9:    return CW'(CLK_HZ / 440);
      4'd10:   return CW'(CLK_HZ / 466);
      4'd11:   return CW'(CLK_HZ / 494);
      default: return '0;
    endcase
  endfunction

  state_t        state;
  logic [CW-1:0] cnt, cur_p, cur_h;
  logic          armed;
  logic [3:0]    tgt_note;
  logic [DW-1:0] eff_duty;
  logic          rel_done;

  logic          div_busy, res_valid;
  logic [IW-1:0] div_iter;
  logic [NW-1:0] div_num;
  logic [DW-1:0] div_rem;
  logic [CW-1:0] div_quo, div_p, res_h, res_p;
  logic [3:0]    div_note, res_note;
  logic [DW-1:0] div_eff;

  logic [DW:0]   rem_sh, rem_nx;
  logic [CW-1:0] quo_nx;
  logic          q_bit, key_ok, wrap, go_idle, load_now, need_div;
  logic          unused_bits;

  assign active      = (state != IDLE);
  assign unused_bits = ^{div_quo[CW-1], rem_nx[DW]};

  always_comb begin
    key_ok   = (key_code <= 4'd11);
    wrap     = armed && (cnt == cur_p - CW'(1));
    go_idle  = (state == RELEASE) && rel_done && (!armed || wrap);
    // first result after a press is applied at once; later ones wait for the wrap
    load_now = (state != IDLE) && res_valid && (!armed || wrap) && !go_idle;
    need_div = (state != IDLE) && ((tgt_note != div_note) || (eff_duty != div_eff));
    rem_sh   = {div_rem, div_num[NW-1]};
    q_bit    = (rem_sh >= (DW+1)'(DUTY_MAX));
    rem_nx   = q_bit ? rem_sh - (DW+1)'(DUTY_MAX) : rem_sh;
    quo_nx   = {div_quo[CW-2:0], q_bit};
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      duty <= DW'(DUTY_RESET);
    end else if (duty_up && !duty_down) begin
      duty <= (duty >= DW'(DUTY_MAX - DUTY_STEP)) ? DW'(DUTY_MAX) : duty + DW'(DUTY_STEP);
    end else if (duty_down && !duty_up) begin
      duty <= (duty <= DW'(DUTY_STEP)) ? '0 : duty - DW'(DUTY_STEP);
    end
  end

`ifdef TONE_ENVELOPE_EN
  localparam int unsigned KW = $clog2(DECAY_TICKS + 1);
  logic [KW-1:0] decay_cnt;
  logic [DW-1:0] env;

  assign eff_duty = (state == RELEASE) ? env : duty;
  assign rel_done = (env == '0);

  // env shadows duty outside RELEASE so the decay starts from the user duty
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      decay_cnt <= '0;
      env       <= '0;
    end else if (state != RELEASE) begin
      decay_cnt <= '0;
      env       <= duty;
    end else if (decay_cnt == KW'(DECAY_TICKS - 1)) begin
      decay_cnt <= '0;
      env       <= (env <= DW'(DUTY_STEP)) ? '0 : env - DW'(DUTY_STEP);
    end else begin
      decay_cnt <= decay_cnt + KW'(1);
    end
  end
`else
  assign eff_duty = duty;
  assign rel_done = 1'b1;
`endif

  // restoring divider: H = P * eff_duty / DUTY_MAX, restarted on any input change
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      div_busy  <= 1'b0;
      res_valid <= 1'b0;
      div_iter  <= '0;
      div_num   <= '0;
      div_rem   <= '0;
      div_quo   <= '0;
      div_p     <= '0;
      div_note  <= 4'hF;
      div_eff   <= '0;
      res_h     <= '0;
      res_p     <= '0;
      res_note  <= 4'hF;
    end else if (state == IDLE) begin
      div_busy  <= 1'b0;
      res_valid <= 1'b0;
      div_note  <= 4'hF;
    end else if (need_div) begin
      div_busy  <= 1'b1;
      res_valid <= 1'b0;
      div_iter  <= '0;
      div_rem   <= '0;
      div_quo   <= '0;
      div_num   <= NW'(note_period(tgt_note)) * NW'(eff_duty);
      div_p     <= note_period(tgt_note);
      div_note  <= tgt_note;
      div_eff   <= eff_duty;
    end else if (div_busy) begin
      div_num  <= {div_num[NW-2:0], 1'b0};
      div_rem  <= rem_nx[DW-1:0];
      div_quo  <= quo_nx;
      div_iter <= div_iter + IW'(1);
      if (div_iter == IW'(NW - 1)) begin
        div_busy  <= 1'b0;
        res_valid <= 1'b1;
        res_h     <= quo_nx;
        res_p     <= div_p;
        res_note  <= div_note;
      end
    end else if (load_now) begin
      res_valid <= 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      cur_p    <= '0;
      cur_h    <= '0;
      armed    <= 1'b0;
      tgt_note <= 4'hF;
      note_idx <= 4'hF;
      tone_out <= 1'b0;
    end else if (state == IDLE) begin
      cnt      <= '0;
      tone_out <= 1'b0;
      armed    <= 1'b0;
      note_idx <= 4'hF;
      if (key_valid && key_ok) begin
        tgt_note <= key_code;
        cur_p    <= note_period(key_code);
        cur_h    <= '0;
        state    <= PLAY;
      end
    end else begin
      case (state)
        PLAY: begin
          if (!key_valid)
            state <= RELEASE;
          else if (key_ok)
            tgt_note <= key_code;
        end
        RELEASE: begin
`ifdef TONE_ENVELOPE_EN
          if (key_valid && key_ok) begin
            state    <= PLAY;
            tgt_note <= key_code;
          end
`endif
        end
        default: ;
      endcase

      if (go_idle) begin
        state    <= IDLE;
        cnt      <= '0;
        tone_out <= 1'b0;
        armed    <= 1'b0;
        note_idx <= 4'hF;
      end else if (load_now) begin
        cur_p    <= res_p;
        cur_h    <= res_h;
        note_idx <= res_note;
        cnt      <= '0;
        armed    <= 1'b1;
        tone_out <= (res_h != '0);
      end else if (wrap) begin
        cnt      <= '0;
        tone_out <= (cur_h != '0);
      end else if (armed) begin
        cnt      <= cnt + CW'(1);
        tone_out <= ((cnt + CW'(1)) < cur_h);
      end
    end
  end

endmodule
